// File: rtl/wrn_wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wrn_wb_rr_arbiter
//
// Round-robin arbiter that shares a single classic Wishbone slave among
// g_num_masters requesters (VME host bridge plus the node CPU cores'
// shared-memory and mqueue ports).
//
// A grant covers a whole bus cycle, from cyc rising to cyc falling, and is
// never preempted. A per-access watchdog answers a stuck access with an
// error so that a dead slave cannot lock the bus.
//
// Optional build macro: WRN_ARB_HOST_PRIO_EN
//   defined   : master 0 (VME host) wins every arbitration it takes part in.
//               Masters 1..N-1 share round-robin among themselves.
//   undefined : plain round-robin over all masters.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module wrn_wb_rr_arbiter #(
    parameter int g_num_masters = 4,
    parameter int g_addr_width  = 32,
    parameter int g_data_width  = 32,
    parameter int g_timeout     = 1023
) (
    input  logic                                    clk_sys_i,
    input  logic                                    rst_n_i,

    // Master side
    input  logic [g_num_masters-1:0]                m_cyc_i,
    input  logic [g_num_masters-1:0]                m_stb_i,
    input  logic [g_num_masters-1:0]                m_we_i,
    input  logic [g_num_masters*g_addr_width-1:0]   m_adr_i,
    input  logic [g_num_masters*g_data_width-1:0]   m_dat_i,
    input  logic [g_num_masters*g_data_width/8-1:0] m_sel_i,
    output logic [g_num_masters-1:0]                m_ack_o,
    output logic [g_num_masters-1:0]                m_err_o,
    output logic [g_data_width-1:0]                 m_dat_o,

    // Slave side
    output logic                                    s_cyc_o,
    output logic                                    s_stb_o,
    output logic                                    s_we_o,
    output logic [g_addr_width-1:0]                 s_adr_o,
    output logic [g_data_width-1:0]                 s_dat_o,
    output logic [g_data_width/8-1:0]               s_sel_o,
    input  logic [g_data_width-1:0]                 s_dat_i,
    input  logic                                    s_ack_i,
    input  logic                                    s_err_i,

    // Status
    output logic [g_num_masters-1:0]                grant_o,
    output logic                                    timeout_o
);

    localparam int N  = g_num_masters;
    localparam int AW = g_addr_width;
    localparam int DW = g_data_width;
    localparam int SW = g_data_width / 8;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [15:0] TimeoutLimit = 16'(g_timeout);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_ABORT = 2'd2
    } state_t;

    // Registered state
    state_t          state_q,     state_d;
    logic [N-1:0]    grant_q,     grant_d;
    logic [IW-1:0]   grantIdx_q,  grantIdx_d;
    logic [IW-1:0]   lastGrant_q, lastGrant_d;
    logic [15:0]     wdCnt_q,     wdCnt_d;

    // Arbitration result for the current IDLE cycle
    logic            winnerFound;
    logic [IW-1:0]   winnerIdx;

    // Signals of the currently granted master
    logic            selCyc;
    logic            selStb;
    logic            selWe;
    logic [AW-1:0]   selAdr;
    logic [DW-1:0]   selDat;
    logic [SW-1:0]   selSel;

    // Slave response and watchdog expiry for the current cycle
    logic            responded;
    logic            expire;

    // Pick the next owner: the first requester after the last owner, wrapping.
    // With host priority, master 0 short-circuits the search and the remaining
    // masters rotate among themselves using the same pointer, which is never
    // loaded with 0 in that build.
    always_comb begin
        int cand;
        winnerFound = 1'b0;
        winnerIdx   = '0;
        cand        = 0;
`ifdef WRN_ARB_HOST_PRIO_EN
        if (m_cyc_i[0]) begin
            winnerFound = 1'b1;
            winnerIdx   = '0;
        end else begin
            for (int i = 1; i < N; i++) begin
                cand = 1 + ((int'(lastGrant_q) - 1 + i) % (N - 1));
                if (!winnerFound && m_cyc_i[cand]) begin
                    winnerFound = 1'b1;
                    winnerIdx   = IW'(cand);
                end
            end
        end
`else
        for (int i = 1; i <= N; i++) begin
            cand = (int'(lastGrant_q) + i) % N;
            if (!winnerFound && m_cyc_i[cand]) begin
                winnerFound = 1'b1;
                winnerIdx   = IW'(cand);
            end
        end
`endif
    end

    // Route the granted master's request signals towards the slave mux.
    always_comb begin
        selCyc = m_cyc_i[grantIdx_q];
        selStb = m_stb_i[grantIdx_q];
        selWe  = m_we_i[grantIdx_q];
        selAdr = m_adr_i[int'(grantIdx_q)*AW +: AW];
        selDat = m_dat_i[int'(grantIdx_q)*DW +: DW];
        selSel = m_sel_i[int'(grantIdx_q)*SW +: SW];
    end

    // Watchdog expiry: a live strobe waited the full limit with no answer.
    // A response arriving in the same cycle takes precedence over expiry.
    always_comb begin
        responded = s_ack_i | s_err_i;
        expire    = (state_q == S_BUSY) && selCyc && selStb && !responded
                    && (wdCnt_q == TimeoutLimit);
    end

    // Next-state logic and all bus outputs; everything is quiet outside a grant.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grantIdx_d  = grantIdx_q;
        lastGrant_d = lastGrant_q;
        wdCnt_d     = '0;

        s_cyc_o     = 1'b0;
        s_stb_o     = 1'b0;
        s_we_o      = 1'b0;
        s_adr_o     = '0;
        s_dat_o     = '0;
        s_sel_o     = '0;
        m_ack_o     = '0;
        m_err_o     = '0;
        m_dat_o     = '0;
        timeout_o   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (winnerFound) begin
                    state_d    = S_BUSY;
                    grantIdx_d = winnerIdx;
                    grant_d    = N'(1) << winnerIdx;
                end
            end

            S_BUSY: begin
                s_cyc_o = 1'b1;
                s_stb_o = selStb & ~expire;
                s_we_o  = selWe;
                s_adr_o = selAdr;
                s_dat_o = selDat;
                s_sel_o = selSel;
                m_dat_o = s_dat_i;

                if (expire) begin
                    m_err_o[grantIdx_q] = 1'b1;
                    timeout_o           = 1'b1;
                end else begin
                    m_ack_o[grantIdx_q] = s_ack_i;
                    m_err_o[grantIdx_q] = s_err_i;
                end

                if (!selCyc) begin
                    state_d = S_IDLE;
                    grant_d = '0;
`ifdef WRN_ARB_HOST_PRIO_EN
                    if (grantIdx_q != '0) begin
                        lastGrant_d = grantIdx_q;
                    end
`else
                    lastGrant_d = grantIdx_q;
`endif
                end else if (expire) begin
                    state_d = S_ABORT;
                end else if (selStb && !responded) begin
                    wdCnt_d = wdCnt_q + 16'd1;
                end
            end

            S_ABORT: begin
                s_cyc_o = 1'b1;
                s_we_o  = selWe;
                s_adr_o = selAdr;
                s_dat_o = selDat;
                s_sel_o = selSel;

                if (!selCyc) begin
                    state_d = S_IDLE;
                    grant_d = '0;
`ifdef WRN_ARB_HOST_PRIO_EN
                    if (grantIdx_q != '0) begin
                        lastGrant_d = grantIdx_q;
                    end
`else
                    lastGrant_d = grantIdx_q;
`endif
                end else if (!selStb) begin
                    state_d = S_BUSY;
                end
            end

            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State register; reset leaves the pointer on the last master so that
    // master 0 (or master 1 among the rotating group) is served first.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            grantIdx_q  <= '0;
            lastGrant_q <= IW'(N - 1);
            wdCnt_q     <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grantIdx_q  <= grantIdx_d;
            lastGrant_q <= lastGrant_d;
            wdCnt_q     <= wdCnt_d;
        end
    end

    assign grant_o = grant_q;

endmodule

// File: tb/tb_wrn_wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wrn_wb_rr_arbiter
//
// Directed bench for wrn_wb_rr_arbiter with 4 masters and a watchdog limit
// of 10 cycles. Single-master scenarios are per-cycle vector tables; the
// rotating multi-master traffic and the mid-cycle reset are written out
// by hand. With WRN_ARB_HOST_PRIO_EN defined the rotation scenario is
// replaced by the host-priority scenario.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_wrn_wb_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 10;

    logic              clk;
    logic              rstN;
    logic [N-1:0]      mCyc, mStb, mWe;
    logic [N*AW-1:0]   mAdr;
    logic [N*DW-1:0]   mDat;
    logic [N*SW-1:0]   mSel;
    logic [N-1:0]      mAck, mErr;
    logic [DW-1:0]     mDatO;
    logic              sCyc, sStb, sWe;
    logic [AW-1:0]     sAdr;
    logic [DW-1:0]     sDatO;
    logic [SW-1:0]     sSel;
    logic [DW-1:0]     sDatI;
    logic              sAck, sErr;
    logic [N-1:0]      grant;
    logic              timeoutPulse;

    int nChecks = 0;
    int nFails  = 0;

    logic [AW-1:0] busAdrExp;
    logic [DW-1:0] busDatExp;
    logic          busWeExp;
    logic [SW-1:0] busSelExp;

    // One clock cycle of stimulus plus the outputs expected in that cycle
    typedef struct packed {
        logic [N-1:0] cyc;
        logic [N-1:0] stb;
        logic [N-1:0] we;
        logic         ack;
        logic         err;
        logic         expCyc;
        logic         expStb;
        logic [N-1:0] expGrant;
        logic [N-1:0] expAck;
        logic [N-1:0] expErr;
        logic         expTo;
        logic         chkBus;
    } vec_t;

    vec_t vecQ[$];

    wrn_wb_rr_arbiter #(
        .g_num_masters (N),
        .g_addr_width  (AW),
        .g_data_width  (DW),
        .g_timeout     (TO)
    ) dut (
        .clk_sys_i (clk),
        .rst_n_i   (rstN),
        .m_cyc_i   (mCyc),
        .m_stb_i   (mStb),
        .m_we_i    (mWe),
        .m_adr_i   (mAdr),
        .m_dat_i   (mDat),
        .m_sel_i   (mSel),
        .m_ack_o   (mAck),
        .m_err_o   (mErr),
        .m_dat_o   (mDatO),
        .s_cyc_o   (sCyc),
        .s_stb_o   (sStb),
        .s_we_o    (sWe),
        .s_adr_o   (sAdr),
        .s_dat_o   (sDatO),
        .s_sel_o   (sSel),
        .s_dat_i   (sDatI),
        .s_ack_i   (sAck),
        .s_err_i   (sErr),
        .grant_o   (grant),
        .timeout_o (timeoutPulse)
    );

    // 100 MHz system clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Address each master presents during the rotation scenarios
    function automatic logic [AW-1:0] adrOf(input int k);
        return 32'h0001_0000 * (k + 1) + 32'h40;
    endfunction

    // Read data the bench slave returns for a given address
    function automatic logic [DW-1:0] slaveData(input logic [AW-1:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic vec_t mkVec(
        input logic [N-1:0] cyc, input logic [N-1:0] stb, input logic [N-1:0] we,
        input logic ack, input logic err,
        input logic expCyc, input logic expStb, input logic [N-1:0] expGrant,
        input logic [N-1:0] expAck, input logic [N-1:0] expErr, input logic expTo,
        input logic chkBus);
        vec_t v;
        v.cyc = cyc;       v.stb = stb;        v.we = we;
        v.ack = ack;       v.err = err;
        v.expCyc = expCyc; v.expStb = expStb;  v.expGrant = expGrant;
        v.expAck = expAck; v.expErr = expErr;  v.expTo = expTo;
        v.chkBus = chkBus;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        mCyc = v.cyc;
        mStb = v.stb;
        mWe  = v.we;
        sAck = v.ack;
        sErr = v.err;
    endtask

    // Play the queued vectors one per cycle, checking mid-cycle
    task automatic runTable(input string tag);
        foreach (vecQ[i]) begin
            @(posedge clk);
            #1;
            applyStimulus(vecQ[i]);
            #2;
            checkOutput($sformatf("%s[%0d] s_cyc", tag, i), 64'(sCyc), 64'(vecQ[i].expCyc));
            checkOutput($sformatf("%s[%0d] s_stb", tag, i), 64'(sStb), 64'(vecQ[i].expStb));
            checkOutput($sformatf("%s[%0d] grant", tag, i), 64'(grant), 64'(vecQ[i].expGrant));
            checkOutput($sformatf("%s[%0d] m_ack", tag, i), 64'(mAck), 64'(vecQ[i].expAck));
            checkOutput($sformatf("%s[%0d] m_err", tag, i), 64'(mErr), 64'(vecQ[i].expErr));
            checkOutput($sformatf("%s[%0d] timeout", tag, i), 64'(timeoutPulse), 64'(vecQ[i].expTo));
            if (vecQ[i].chkBus) begin
                checkOutput($sformatf("%s[%0d] s_adr", tag, i), 64'(sAdr), 64'(busAdrExp));
                checkOutput($sformatf("%s[%0d] s_dat", tag, i), 64'(sDatO), 64'(busDatExp));
                checkOutput($sformatf("%s[%0d] s_we", tag, i), 64'(sWe), 64'(busWeExp));
                checkOutput($sformatf("%s[%0d] s_sel", tag, i), 64'(sSel), 64'(busSelExp));
            end
        end
        vecQ.delete();
    endtask

    // One complete single-read grant to master e while the masters in mask
    // request: idle turnaround cycle, acked access, then master e releases.
    task automatic runGrant(input int e, input logic [N-1:0] mask, input string tag);
        logic [N-1:0] oneHot;
        oneHot = N'(1) << e;
        @(posedge clk);
        #1;
        mCyc = mask; mStb = mask; mWe = '0; sAck = 1'b0;
        #2;
        checkOutput({tag, " idle s_cyc"}, 64'(sCyc), 64'd0);
        checkOutput({tag, " idle grant"}, 64'(grant), 64'd0);
        @(posedge clk);
        #1;
        sAck  = 1'b1;
        sDatI = slaveData(adrOf(e));
        #2;
        checkOutput({tag, " grant"}, 64'(grant), 64'(oneHot));
        checkOutput({tag, " s_adr"}, 64'(sAdr), 64'(adrOf(e)));
        checkOutput({tag, " m_ack"}, 64'(mAck), 64'(oneHot));
        checkOutput({tag, " m_dat"}, 64'(mDatO), 64'(slaveData(adrOf(e))));
        @(posedge clk);
        #1;
        sAck = 1'b0;
        mCyc = mask & ~oneHot;
        mStb = mask & ~oneHot;
        #2;
        checkOutput({tag, " release s_cyc"}, 64'(sCyc), 64'd1);
        checkOutput({tag, " release m_ack"}, 64'(mAck), 64'd0);
    endtask

    initial begin
        rstN  = 1'b0;
        mCyc  = '0; mStb = '0; mWe = '0;
        mSel  = '1;
        sDatI = '0; sAck = 1'b0; sErr = 1'b0;
        for (int k = 0; k < N; k++) begin
            mAdr[k*AW +: AW] = adrOf(k);
            mDat[k*DW +: DW] = 32'hD000_0000 + 32'(k);
        end
        busAdrExp = '0; busDatExp = '0; busWeExp = 1'b0; busSelExp = '0;

        // Outputs while held in reset
        #3;
        checkOutput("reset s_cyc", 64'(sCyc), 64'd0);
        checkOutput("reset s_stb", 64'(sStb), 64'd0);
        checkOutput("reset grant", 64'(grant), 64'd0);
        checkOutput("reset m_ack", 64'(mAck), 64'd0);
        checkOutput("reset m_err", 64'(mErr), 64'd0);
        checkOutput("reset timeout", 64'(timeoutPulse), 64'd0);
        checkOutput("reset s_adr", 64'(sAdr), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstN = 1'b1;

`ifdef WRN_ARB_HOST_PRIO_EN
        // Host wins every arbitration; then 1..3 rotate starting at 1
        for (int n = 0; n < 3; n++) begin
            runGrant(0, 4'b1111, $sformatf("prio host #%0d", n));
        end
        runGrant(1, 4'b1110, "prio rr 1");
        runGrant(2, 4'b1110, "prio rr 2");
        runGrant(3, 4'b1110, "prio rr 3");
        runGrant(1, 4'b1110, "prio rr 1b");
`else
        // All four masters saturate the bus: strict rotation 0,1,2,3,...
        for (int n = 0; n < 12; n++) begin
            runGrant(n % N, 4'b1111, $sformatf("rr #%0d m%0d", n, n % N));
        end
`endif

        // Master 2 alone writes 0x1234 to 0x34000, slave acks 3 cycles later
        mAdr[2*AW +: AW] = 32'h0003_4000;
        mDat[2*DW +: DW] = 32'h0000_1234;
        busAdrExp = 32'h0003_4000;
        busDatExp = 32'h0000_1234;
        busWeExp  = 1'b1;
        busSelExp = 4'hF;
        vecQ.push_back(mkVec(4'b0100, 4'b0100, 4'b0100, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
        for (int k = 0; k < 3; k++)
            vecQ.push_back(mkVec(4'b0100, 4'b0100, 4'b0100, 0, 0, 1, 1, 4'b0100, 4'b0000, 4'b0000, 0, 1));
        vecQ.push_back(mkVec(4'b0100, 4'b0100, 4'b0100, 1, 0, 1, 1, 4'b0100, 4'b0100, 4'b0000, 0, 1));
        vecQ.push_back(mkVec(4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 0, 4'b0100, 4'b0000, 4'b0000, 0, 0));
        vecQ.push_back(mkVec(4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
        vecQ.push_back(mkVec(4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
        runTable("write m2");

        // Ack lands exactly when the watchdog reaches its limit: ack wins
        vecQ.push_back(mkVec(4'b0010, 4'b0010, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
        for (int k = 0; k < TO; k++)
            vecQ.push_back(mkVec(4'b0010, 4'b0010, 4'b0000, 0, 0, 1, 1, 4'b0010, 4'b0000, 4'b0000, 0, 0));
        vecQ.push_back(mkVec(4'b0010, 4'b0010, 4'b0000, 1, 0, 1, 1, 4'b0010, 4'b0010, 4'b0000, 0, 0));
        vecQ.push_back(mkVec(4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 0, 4'b0010, 4'b0000, 4'b0000, 0, 0));
        vecQ.push_back(mkVec(4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
        runTable("ack at limit");

        // Dead slave: expiry, abort, retry, then hand-over to master 0
        vecQ.push_back(mkVec(4'b0010, 4'b0010, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
        for (int k = 0; k < TO; k++)
            vecQ.push_back(mkVec(4'b0010, 4'b0010, 4'b0000, 0, 0, 1, 1, 4'b0010, 4'b0000, 4'b0000, 0, 0));
        vecQ.push_back(mkVec(4'b0010, 4'b0010, 4'b0000, 0, 0, 1, 0, 4'b0010, 4'b0000, 4'b0010, 1, 0));
        vecQ.push_back(mkVec(4'b0010, 4'b0010, 4'b0000, 0, 0, 1, 0, 4'b0010, 4'b0000, 4'b0000, 0, 0));
        vecQ.push_back(mkVec(4'b0010, 4'b0000, 4'b0000, 0, 0, 1, 0, 4'b0010, 4'b0000, 4'b0000, 0, 0));
        vecQ.push_back(mkVec(4'b0010, 4'b0010, 4'b0000, 1, 0, 1, 1, 4'b0010, 4'b0010, 4'b0000, 0, 0));
        vecQ.push_back(mkVec(4'b0001, 4'b0001, 4'b0000, 0, 0, 1, 0, 4'b0010, 4'b0000, 4'b0000, 0, 0));
        vecQ.push_back(mkVec(4'b0001, 4'b0001, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
        vecQ.push_back(mkVec(4'b0001, 4'b0001, 4'b0000, 0, 0, 1, 1, 4'b0001, 4'b0000, 4'b0000, 0, 0));
        vecQ.push_back(mkVec(4'b0001, 4'b0001, 4'b0000, 1, 0, 1, 1, 4'b0001, 4'b0001, 4'b0000, 0, 0));
        vecQ.push_back(mkVec(4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 0, 4'b0001, 4'b0000, 4'b0000, 0, 0));
        vecQ.push_back(mkVec(4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
        runTable("timeout m1");

        // Slave error is routed only to the owner (master 3)
        vecQ.push_back(mkVec(4'b1000, 4'b1000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
        vecQ.push_back(mkVec(4'b1000, 4'b1000, 4'b0000, 0, 1, 1, 1, 4'b1000, 4'b0000, 4'b1000, 0, 0));
        vecQ.push_back(mkVec(4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 0, 4'b1000, 4'b0000, 4'b0000, 0, 0));
        vecQ.push_back(mkVec(4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
        runTable("slave err m3");

        // Reset in the middle of a master 3 access drops the bus at once
        @(posedge clk);
        #1;
        mCyc = 4'b1000; mStb = 4'b1000; mWe = 4'b0000;
        @(posedge clk);
        #1;
        checkOutput("midrst pre s_cyc", 64'(sCyc), 64'd1);
        checkOutput("midrst pre grant", 64'(grant), 64'b1000);
        sAck = 1'b1;
        #1;
        rstN = 1'b0;
        #1;
        checkOutput("midrst s_cyc", 64'(sCyc), 64'd0);
        checkOutput("midrst s_stb", 64'(sStb), 64'd0);
        checkOutput("midrst grant", 64'(grant), 64'd0);
        checkOutput("midrst m_ack", 64'(mAck), 64'd0);
        @(posedge clk);
        #1;
        sAck = 1'b0;
        mCyc = 4'b1001; mStb = 4'b1001;
        rstN = 1'b1;
        #2;
        checkOutput("postrst idle s_cyc", 64'(sCyc), 64'd0);
        @(posedge clk);
        #3;
        checkOutput("postrst grant m0", 64'(grant), 64'b0001);
        checkOutput("postrst s_cyc", 64'(sCyc), 64'd1);
        @(posedge clk);
        #1;
        mCyc = '0; mStb = '0;
        @(posedge clk);
        @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
